multi_adder_pipe: RTL and testbench
===================================

MULTI_ADDER_PIPE -- requirements
Module: multi_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width per channel.
REQ-002 SHALL have parameter NUM_CH, default 2, number of independent adder channels (>=1).
REQ-003 SHALL have parameter SWIDTH, default WIDTH+1, per-channel sum width.
REQ-004 SHALL have parameter AWIDTH, default WIDTH+4, per-channel accumulator width (>=SWIDTH).
REQ-005 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid  in  1  input transfer offered.
REQ-008 SHALL have port in_ready  out  1  input transfer accepted when in_valid&in_ready.
REQ-009 SHALL have port cin  in  NUM_CH  carry-in, bit c for channel c.
REQ-010 SHALL have port x  in  NUM_CH*WIDTH  operand A, channel c at [c*WIDTH +: WIDTH].
REQ-011 SHALL have port y  in  NUM_CH*WIDTH  operand B, same packing as x.
REQ-012 SHALL have port acc_mode  in  1  1: add this sum into accumulators; 0: accumulators hold.
REQ-013 SHALL have port acc_clr  in  1  1: load accumulators with this sum, clear overflow.
REQ-014 SHALL have port out_valid  out  1  result available.
REQ-015 SHALL have port out_ready  in  1  result consumed when out_valid&out_ready.
REQ-016 SHALL have port sum  out  NUM_CH*SWIDTH  per-channel x+y+cin, channel c at [c*SWIDTH +: SWIDTH].
REQ-017 SHALL have port acc  out  NUM_CH*AWIDTH  per-channel accumulator.
REQ-018 SHALL have port zero  out  NUM_CH  bit c = (sum of channel c == 0).
REQ-019 SHALL have port ovf  out  NUM_CH  sticky accumulator overflow per channel.

Function
REQ-020 SHALL compute per channel s = x+y+cin at full SWIDTH precision, zero-extended, registered in stage 1 with acc_mode/acc_clr.
REQ-021 SHALL register sum, zero, acc, ovf in stage 2; out_valid asserts 2 cycles after acceptance when not stalled.
REQ-022 SHALL advance stage 2 when !out_valid | out_ready; stage 1 when stage 1 empty or stage 2 advances.
REQ-023 SHALL drive in_ready = !s1_valid | stage-2-advance (combinational); 0 while rst high.
REQ-024 SHALL sustain one transfer per cycle with in_valid=out_ready=1; no bubbles, no loss, no duplication, order preserved.
REQ-025 SHALL hold sum/acc/zero/ovf/out_valid stable while out_valid&!out_ready.
REQ-026 SHALL on stage-2 load with acc_clr=1 set acc=s, ovf=0 (acc_clr priority over acc_mode).
REQ-027 SHALL on stage-2 load with acc_clr=0, acc_mode=1 set acc=acc+s modulo 2^AWIDTH; set ovf if carry-out of AWIDTH.
REQ-028 SHALL on stage-2 load with acc_clr=0, acc_mode=0 leave acc and ovf unchanged.
REQ-029 SHALL update accumulators only on stage-2 load, never on stalled cycles.

Reset
REQ-030 SHALL on rst=1 immediately clear both stage valids, out_valid, sum, acc, zero, ovf to 0, discarding in-flight data.
REQ-031 SHALL accept a new transfer on the first clk edge with rst=0 and in_valid=1.

Configuration
REQ-032 SHALL with MULTI_ADDER_PIPE_SAT_EN defined clamp acc to 2^AWIDTH-1 on carry-out instead of wrapping; ovf still sets.
REQ-033 SHALL without MULTI_ADDER_PIPE_SAT_EN wrap accumulators modulo 2^AWIDTH; all other behaviour identical.

Verification (WIDTH=8, NUM_CH=2, AWIDTH=12)
REQ-034 SHALL check: one transfer ch0 x=0xFF,y=0x01,cin=1; ch1 x=y=cin=0, out_ready=1 -> 2 cycles later out_valid=1, sum0=0x101, zero0=0, sum1=0, zero1=1.
REQ-035 SHALL check: in_valid=out_ready=1 for 10 transfers of x=k,y=k -> out_valid cycles 2..11, sum0=2k in order, in_ready constant 1.
REQ-036 SHALL check: out_ready=0, offer 3 transfers -> 2 accepted, in_ready=0 on third; outputs stable; release out_ready -> all 3 delivered in order.
REQ-037 SHALL check: acc_clr transfer with s0=0x1FF, then 7 acc_mode transfers of s0=0x1FF -> acc0=0xFF8, ovf0=0; one more -> acc0=0x1F7 ovf0=1 (SAT_EN: 0xFFF ovf0=1); acc_clr transfer -> ovf0=0.
REQ-038 SHALL check: rst pulsed while 2 transfers in flight and out_ready=0 -> out_valid, sum, acc, ovf 0 same cycle; no stale output after release.
REQ-039 SHALL check: acc_clr=acc_mode=1 with s0=0x005 after acc0=0x100 -> acc0=0x005 (clear wins).

Source files
------------

// File: rtl/multi_adder_pipe.sv
// -----------------------------------------------------------------------------
// multi_adder_pipe
//
// This is a two-stage pipelined bank of NUM_CH independent adders. Each channel
// also has a running accumulator.
//
//   Stage 1 : For each channel, s = x + y + cin. The sum has SWIDTH bits and is
//             zero-extended. It is registered together with acc_mode and
//             acc_clr.
//   Stage 2 : sum, zero, acc and ovf are registered here. The accumulators
//             change only when stage 2 loads a valid stage-1 entry.
//
// Handshake (valid/ready):
//   - A transfer happens on a rising edge when valid && ready are both high.
//   - A producer holding valid keeps its payload stable until the transfer.
//   - Stage 2 advances when !out_valid || out_ready.
//   - Stage 1 advances when it is empty or when stage 2 advances.
//   - in_ready is a combinational copy of the stage-1 advance condition. It is
//     forced low while rst is high.
//   - While out_valid && !out_ready, every output stays frozen.
//
// Optional feature:
//   MULTI_ADDER_PIPE_SAT_EN : when defined, an accumulator carry-out clamps acc
//                             to all ones instead of wrapping. ovf is set in
//                             both builds.
//
// Ports:
//   clk        single clock; all state updates on the rising edge
//   rst        asynchronous, active-high reset; discards all in-flight data
//   in_valid   input transfer offered
//   in_ready   input transfer accepted when in_valid & in_ready
//   cin        carry-in; bit c belongs to channel c
//   x, y       operands; channel c is at [c*WIDTH +: WIDTH]
//   acc_mode   1: add this sum into the accumulators; 0: accumulators hold
//   acc_clr    1: load the accumulators with this sum and clear ovf
//                 (takes priority over acc_mode)
//   out_valid  result available
//   out_ready  result consumed when out_valid & out_ready
//   sum        per-channel x+y+cin; channel c is at [c*SWIDTH +: SWIDTH]
//   acc        per-channel accumulator; channel c is at [c*AWIDTH +: AWIDTH]
//   zero       bit c = (sum of channel c == 0)
//   ovf        per-channel sticky accumulator overflow
// -----------------------------------------------------------------------------
module multi_adder_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 2,
  parameter int SWIDTH = WIDTH + 1,
  parameter int AWIDTH = WIDTH + 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CH-1:0]          cin,
  input  logic [NUM_CH*WIDTH-1:0]    x,
  input  logic [NUM_CH*WIDTH-1:0]    y,
  input  logic                       acc_mode,
  input  logic                       acc_clr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_CH*SWIDTH-1:0]   sum,
  output logic [NUM_CH*AWIDTH-1:0]   acc,
  output logic [NUM_CH-1:0]          zero,
  output logic [NUM_CH-1:0]          ovf
);

  // The raw add is done wide enough that x+y+cin cannot lose a carry. The
  // result is then cut down to SWIDTH bits.
  localparam int EW  = (SWIDTH > WIDTH + 1) ? SWIDTH : WIDTH + 1;
  // The accumulator add uses one extra bit so the carry-out is visible.
  localparam int AXW = AWIDTH + 1;

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic s1_mode;
  logic s1_clr;
  logic adv2;     // stage 2 may take a new value this cycle
  logic adv1;     // stage 1 may take a new value this cycle
  logic accept;   // input transfer happens on this edge
  logic load2;    // stage 2 captures a valid stage-1 entry on this edge

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1 && !rst;
  assign accept   = in_valid && in_ready;
  assign load2    = adv2 && s1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mode   <= 1'b0;
      s1_clr    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // When stage 1 drains without a new input, it becomes empty.
      if (adv1) begin
        s1_valid <= accept;
      end
      if (accept) begin
        s1_mode <= acc_mode;
        s1_clr  <= acc_clr;
      end
      // When stage 2 advances while stage 1 is empty, out_valid drops. The
      // data registers keep their last value in that case.
      if (adv2) begin
        out_valid <= s1_valid;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel datapath
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [EW-1:0]     raw;
    logic [SWIDTH-1:0] s_next;
    logic [SWIDTH-1:0] s1_sum;
    logic [SWIDTH-1:0] sum_r;
    logic [AWIDTH-1:0] acc_r;
    logic [AXW-1:0]    acc_add;
    logic              zero_r;
    logic              ovf_r;

    assign raw     = EW'(x[c*WIDTH +: WIDTH]) + EW'(y[c*WIDTH +: WIDTH]) + EW'(cin[c]);
    assign s_next  = raw[SWIDTH-1:0];
    assign acc_add = {1'b0, acc_r} + AXW'(s1_sum);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_sum <= '0;
        sum_r  <= '0;
        zero_r <= 1'b0;
        acc_r  <= '0;
        ovf_r  <= 1'b0;
      end else begin
        if (accept) begin
          s1_sum <= s_next;
        end
        if (load2) begin
          sum_r  <= s1_sum;
          zero_r <= (s1_sum == '0);
          if (s1_clr) begin
            acc_r <= AWIDTH'(s1_sum);
            ovf_r <= 1'b0;
          end else if (s1_mode) begin
            if (acc_add[AWIDTH]) begin
              ovf_r <= 1'b1;
`ifdef MULTI_ADDER_PIPE_SAT_EN
              acc_r <= '1;
`else
              acc_r <= acc_add[AWIDTH-1:0];
`endif
            end else begin
              acc_r <= acc_add[AWIDTH-1:0];
            end
          end
        end
      end
    end

    assign sum[c*SWIDTH +: SWIDTH] = sum_r;
    assign acc[c*AWIDTH +: AWIDTH] = acc_r;
    assign zero[c]                 = zero_r;
    assign ovf[c]                  = ovf_r;
  end

endmodule

// File: tb/tb_multi_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_multi_adder_pipe
//
// A directed bench for multi_adder_pipe with WIDTH=8, NUM_CH=2, SWIDTH=9 and
// AWIDTH=12. Inputs are driven 1 time unit after each rising edge. Outputs are
// checked 1 time unit after the edge, or 1 time unit after driving when the
// value checked is the combinational in_ready.
// -----------------------------------------------------------------------------
module tb_multi_adder_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  cin;
  logic [15:0] x;
  logic [15:0] y;
  logic        acc_mode;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] sum;
  logic [23:0] acc;
  logic [1:0]  zero;
  logic [1:0]  ovf;

  int n_assert;
  int n_fail;
  logic [8:0] exp_q[$];
  logic [8:0] exp_s;

  multi_adder_pipe #(
    .WIDTH(8), .NUM_CH(2), .SWIDTH(9), .AWIDTH(12)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cin(cin), .x(x), .y(y), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .acc(acc),
    .zero(zero), .ovf(ovf)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Driver and checker tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] x0, input logic [7:0] y0,
                       input logic [7:0] x1, input logic [7:0] y1,
                       input logic [1:0] c, input logic mode, input logic clr);
    in_valid = 1'b1;
    x        = {x1, x0};
    y        = {y1, y0};
    cin      = c;
    acc_mode = mode;
    acc_clr  = clr;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    x        = '0;
    y        = '0;
    cin      = '0;
    acc_mode = 1'b0;
    acc_clr  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    out_ready = 1'b1;
    idle();

    // Reset state
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_sum", {14'b0, sum}, 32'd0);
    chk("rst_acc", {8'b0, acc}, 32'd0);
    chk("rst_zero", {30'b0, zero}, 32'd0);
    chk("rst_ovf", {30'b0, ovf}, 32'd0);
    step();
    step();
    rst = 1'b0;

    // Single transfer with ch0 carry-through and ch1 all zero
    drive(8'hFF, 8'h01, 8'h00, 8'h00, 2'b01, 1'b0, 1'b0);
    #1 chk("t1_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    idle();
    chk("t1_out_valid_lat1", {31'b0, out_valid}, 32'd0);
    step();
    chk("t1_out_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_sum0", {23'b0, sum[8:0]}, 32'h101);
    chk("t1_zero0", {31'b0, zero[0]}, 32'd0);
    chk("t1_sum1", {23'b0, sum[17:9]}, 32'h0);
    chk("t1_zero1", {31'b0, zero[1]}, 32'd1);
    chk("t1_acc_hold", {8'b0, acc}, 32'd0);
    step();
    chk("t1_drain", {31'b0, out_valid}, 32'd0);

    // Back-to-back streaming of ten transfers
    for (int i = 0; i < 10; i++) begin
      drive(8'(i + 1), 8'(i + 1), 8'(i + 1), 8'(i + 1), 2'b00, 1'b0, 1'b0);
      #1 chk("t2_in_ready", {31'b0, in_ready}, 32'd1);
      exp_q.push_back(9'(2 * (i + 1)));
      step();
      chk("t2_out_valid", {31'b0, out_valid}, (i >= 1) ? 32'd1 : 32'd0);
      if (i >= 1) begin
        exp_s = exp_q.pop_front();
        chk("t2_sum0", {23'b0, sum[8:0]}, {23'b0, exp_s});
        chk("t2_sum1", {23'b0, sum[17:9]}, {23'b0, exp_s});
      end
    end
    idle();
    step();
    chk("t2_last_valid", {31'b0, out_valid}, 32'd1);
    exp_s = exp_q.pop_front();
    chk("t2_last_sum0", {23'b0, sum[8:0]}, {23'b0, exp_s});
    step();
    chk("t2_drain", {31'b0, out_valid}, 32'd0);

    // Backpressure: two transfers fit, the third waits
    out_ready = 1'b0;
    drive(8'h10, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    #1 chk("t3_rdy_a", {31'b0, in_ready}, 32'd1);
    step();
    drive(8'h20, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    #1 chk("t3_rdy_b", {31'b0, in_ready}, 32'd1);
    step();
    chk("t3_valid_a", {31'b0, out_valid}, 32'd1);
    chk("t3_sum_a", {23'b0, sum[8:0]}, 32'h10);
    drive(8'h30, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    #1 chk("t3_rdy_c_blocked", {31'b0, in_ready}, 32'd0);
    step();
    chk("t3_stall_valid", {31'b0, out_valid}, 32'd1);
    chk("t3_stall_sum", {23'b0, sum[8:0]}, 32'h10);
    chk("t3_stall_zero", {30'b0, zero}, 32'b10);
    step();
    chk("t3_stall_sum2", {23'b0, sum[8:0]}, 32'h10);
    chk("t3_rdy_c_still", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1 chk("t3_rdy_c_release", {31'b0, in_ready}, 32'd1);
    step();
    idle();
    chk("t3_sum_b", {23'b0, sum[8:0]}, 32'h20);
    step();
    chk("t3_valid_c", {31'b0, out_valid}, 32'd1);
    chk("t3_sum_c", {23'b0, sum[8:0]}, 32'h30);
    step();
    chk("t3_drain", {31'b0, out_valid}, 32'd0);

    // Accumulator: clear with 0x1FF, then seven adds, then an overflowing add, then clear
    for (int i = 0; i < 10; i++) begin
      drive(8'hFF, 8'hFF, 8'h00, 8'h00, 2'b01, (i >= 1 && i <= 8), (i == 0 || i == 9));
      step();
      if (i == 8) begin
        chk("t4_acc0_ff8", {20'b0, acc[11:0]}, 32'hFF8);
        chk("t4_ovf0_clear", {31'b0, ovf[0]}, 32'd0);
      end
      if (i == 9) begin
`ifdef MULTI_ADDER_PIPE_SAT_EN
        chk("t4_acc0_ovf", {20'b0, acc[11:0]}, 32'hFFF);
`else
        chk("t4_acc0_ovf", {20'b0, acc[11:0]}, 32'h1F7);
`endif
        chk("t4_ovf0_set", {31'b0, ovf[0]}, 32'd1);
        chk("t4_ovf1_clear", {31'b0, ovf[1]}, 32'd0);
        chk("t4_acc1", {20'b0, acc[23:12]}, 32'h0);
      end
    end
    idle();
    step();
    chk("t4_clr_acc0", {20'b0, acc[11:0]}, 32'h1FF);
    chk("t4_clr_ovf0", {31'b0, ovf[0]}, 32'd0);

    // acc_clr wins over acc_mode; acc_mode=0 holds the accumulator
    drive(8'h80, 8'h80, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
    step();
    drive(8'h02, 8'h03, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1);
    step();
    chk("t5_acc0_100", {20'b0, acc[11:0]}, 32'h100);
    drive(8'h03, 8'h04, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    step();
    chk("t5_clr_wins", {20'b0, acc[11:0]}, 32'h005);
    idle();
    step();
    chk("t5_hold_acc0", {20'b0, acc[11:0]}, 32'h005);
    chk("t5_hold_sum0", {23'b0, sum[8:0]}, 32'h007);
    chk("t5_hold_ovf0", {31'b0, ovf[0]}, 32'd0);
    step();

    // Reset while two transfers are in flight and the output is stalled
    out_ready = 1'b0;
    drive(8'h30, 8'h03, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
    step();
    drive(8'h11, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    step();
    idle();
    chk("t6_pre_valid", {31'b0, out_valid}, 32'd1);
    chk("t6_pre_acc0", {20'b0, acc[11:0]}, 32'h033);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_rst_sum", {14'b0, sum}, 32'd0);
    chk("t6_rst_acc", {8'b0, acc}, 32'd0);
    chk("t6_rst_ovf", {30'b0, ovf}, 32'd0);
    chk("t6_rst_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(8'h42, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    #1 chk("t6_rdy_after_rst", {31'b0, in_ready}, 32'd1);
    step();
    idle();
    chk("t6_no_stale", {31'b0, out_valid}, 32'd0);
    step();
    chk("t6_new_valid", {31'b0, out_valid}, 32'd1);
    chk("t6_new_sum0", {23'b0, sum[8:0]}, 32'h042);
    step();
    chk("t6_drain", {31'b0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
